alu_rs_gen: RTL

- Parametrised ALU reservation station for the out-of-order core; sits between the decoder/dispatch and the CDB arbiter.
- Holds NUM_ENTRIES pending ALU ops and captures operands from up to NUM_CDB result broadcasts per cycle, including same-cycle capture at dispatch.
- Each cycle selects the oldest entry whose operands are both available and executes it on one shared ALU (existing alu module).
- Drives a registered result with valid/ready backpressure toward the CDB arbiter.

---
 rtl/ooo_types.sv | 10 +
 rtl/rv32i_types.sv | 15 +
 rtl/alu.sv | 32 +++
 rtl/alu_rs_age_select.sv | 24 ++
 rtl/alu_rs_gen.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/ooo_types.sv
// Shared out-of-order core types: ROB tag type and the "no dependency" tag value.
package ooo_types;

  localparam int unsigned DEF_TAG_W = 4;

  typedef logic [DEF_TAG_W-1:0] tag_t;

  localparam tag_t NO_TAG = '0;

endpackage

// File: rtl/rv32i_types.sv
// RV32I execution types shared by the ALU and its reservation station.
package rv32i_types;

  typedef enum logic [2:0] {
    alu_add = 3'b000,
    alu_sll = 3'b001,
    alu_sra = 3'b010,
    alu_sub = 3'b011,
    alu_xor = 3'b100,
    alu_srl = 3'b101,
    alu_or  = 3'b110,
    alu_and = 3'b111
  } alu_ops;

endpackage

// File: rtl/alu.sv
// Combinational integer ALU; shift amount comes from the low bits of i_b.
module alu
  import rv32i_types::*;
#(
  parameter int unsigned DATA_W = 32
) (
  input  alu_ops            i_op,
  input  logic [DATA_W-1:0] i_a,
  input  logic [DATA_W-1:0] i_b,
  output logic [DATA_W-1:0] o_f
);

  localparam int unsigned ShW = $clog2(DATA_W);

  logic [ShW-1:0] w_sh;
  assign w_sh = i_b[ShW-1:0];

  always_comb begin
    o_f = '0;
    unique case (i_op)
      alu_add: o_f = i_a + i_b;
      alu_sll: o_f = i_a << w_sh;
      alu_sra: o_f = DATA_W'($signed(i_a) >>> w_sh);
      alu_sub: o_f = i_a - i_b;
      alu_xor: o_f = i_a ^ i_b;
      alu_srl: o_f = i_a >> w_sh;
      alu_or:  o_f = i_a | i_b;
      alu_and: o_f = i_a & i_b;
    endcase
  end

endmodule

// File: rtl/alu_rs_age_select.sv
// Oldest-ready picker: grants the ready entry that no other ready entry predates.
module alu_rs_age_select #(
  parameter int unsigned NUM_ENTRIES = 8
) (
  input  logic [NUM_ENTRIES-1:0]                  i_ready,
  input  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] i_older,
  output logic [NUM_ENTRIES-1:0]                  o_grant,
  output logic                                    o_any
);

  // Diagonal of i_older is always 0, so an entry never blocks itself.
  always_comb begin
    o_grant = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      o_grant[i] = i_ready[i];
      for (int j = 0; j < NUM_ENTRIES; j++) begin
        if (i_ready[j] && i_older[j][i]) o_grant[i] = 1'b0;
      end
    end
  end

  assign o_any = |o_grant;

endmodule

// File: rtl/alu_rs_gen.sv
// ALU reservation station: CDB snooping, oldest-ready issue, registered result.
// Optional perf counters enabled by defining ALU_RS_PERF_EN.
module alu_rs_gen
  import ooo_types::*;
  import rv32i_types::*;
#(
  parameter int unsigned NUM_ENTRIES = 8,
  parameter int unsigned NUM_CDB     = 2,
  parameter int unsigned TAG_W       = 4,
  parameter int unsigned DATA_W      = 32
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          disp_valid,
  output logic                          disp_ready,
  input  logic [2:0]                    disp_op,
  input  logic [DATA_W-1:0]             disp_vj,
  input  logic [DATA_W-1:0]             disp_vk,
  input  logic [TAG_W-1:0]              disp_qj,
  input  logic [TAG_W-1:0]              disp_qk,
  input  logic [TAG_W-1:0]              disp_dest,
  input  logic [NUM_CDB-1:0]            cdb_valid,
  input  logic [NUM_CDB*TAG_W-1:0]      cdb_tag,
  input  logic [NUM_CDB*DATA_W-1:0]     cdb_val,
  output logic                          res_valid,
  input  logic                          res_ready,
  output logic [TAG_W-1:0]              res_tag,
  output logic [DATA_W-1:0]             res_val,
`ifdef ALU_RS_PERF_EN
  output logic [31:0]                   perf_issue_cnt,
  output logic [31:0]                   perf_full_cnt,
`endif
  output logic [$clog2(NUM_ENTRIES):0]  occupancy
);

  localparam int unsigned IdxW = $clog2(NUM_ENTRIES);
  localparam int unsigned CntW = IdxW + 1;
  localparam logic [TAG_W-1:0] NoTag = TAG_W'(NO_TAG);

  logic [NUM_ENTRIES-1:0]                  r_busy;
  alu_ops [NUM_ENTRIES-1:0]                r_op;
  logic [NUM_ENTRIES-1:0][DATA_W-1:0]      r_vj, r_vk;
  logic [NUM_ENTRIES-1:0][TAG_W-1:0]       r_qj, r_qk, r_dest;
  logic [NUM_ENTRIES-1:0][NUM_ENTRIES-1:0] r_older;
  logic                                    r_res_valid;
  logic [TAG_W-1:0]                        r_res_tag;
  logic [DATA_W-1:0]                       r_res_val;
  logic [CntW-1:0]                         r_occ;

  logic [NUM_ENTRIES-1:0]             w_ready, w_grant;
  logic                               w_any, w_issue, w_disp;
  logic [IdxW-1:0]                    w_free_idx, w_sel_idx;
  logic [NUM_ENTRIES-1:0][DATA_W-1:0] w_vj_n, w_vk_n;
  logic [NUM_ENTRIES-1:0][TAG_W-1:0]  w_qj_n, w_qk_n;
  logic [DATA_W-1:0]                  w_dvj, w_dvk, w_alu_out;
  logic [TAG_W-1:0]                   w_dqj, w_dqk;

  assign disp_ready = ~&r_busy;
  assign w_disp     = disp_valid && disp_ready && !flush;

  // CAM snoop; ports scanned high-to-low so the lowest matching port wins.
  always_comb begin
    w_vj_n = r_vj;
    w_vk_n = r_vk;
    w_qj_n = r_qj;
    w_qk_n = r_qk;
    w_dvj  = disp_vj;
    w_dvk  = disp_vk;
    w_dqj  = disp_qj;
    w_dqk  = disp_qk;
    for (int p = NUM_CDB - 1; p >= 0; p--) begin
      if (cdb_valid[p]) begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
          if (r_busy[i] && r_qj[i] != NoTag && cdb_tag[p*TAG_W +: TAG_W] == r_qj[i]) begin
            w_qj_n[i] = NoTag;
            w_vj_n[i] = cdb_val[p*DATA_W +: DATA_W];
          end
          if (r_busy[i] && r_qk[i] != NoTag && cdb_tag[p*TAG_W +: TAG_W] == r_qk[i]) begin
            w_qk_n[i] = NoTag;
            w_vk_n[i] = cdb_val[p*DATA_W +: DATA_W];
          end
        end
        if (disp_qj != NoTag && cdb_tag[p*TAG_W +: TAG_W] == disp_qj) begin
          w_dqj = NoTag;
          w_dvj = cdb_val[p*DATA_W +: DATA_W];
        end
        if (disp_qk != NoTag && cdb_tag[p*TAG_W +: TAG_W] == disp_qk) begin
          w_dqk = NoTag;
          w_dvk = cdb_val[p*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin
    w_free_idx = '0;
    w_sel_idx  = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      w_ready[i] = r_busy[i] && r_qj[i] == NoTag && r_qk[i] == NoTag;
      if (!r_busy[i]) w_free_idx = IdxW'(i);
      if (w_grant[i]) w_sel_idx = IdxW'(i);
    end
  end

  alu_rs_age_select #(
    .NUM_ENTRIES(NUM_ENTRIES)
  ) u_age_select (
    .i_ready(w_ready),
    .i_older(r_older),
    .o_grant(w_grant),
    .o_any  (w_any)
  );

  alu #(
    .DATA_W(DATA_W)
  ) u_alu (
    .i_op(r_op[w_sel_idx]),
    .i_a (r_vj[w_sel_idx]),
    .i_b (r_vk[w_sel_idx]),
    .o_f (w_alu_out)
  );

  assign w_issue = (!r_res_valid || res_ready) && w_any && !flush;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_busy      <= '0;
      r_vj        <= '0;
      r_vk        <= '0;
      r_qj        <= '0;
      r_qk        <= '0;
      r_dest      <= '0;
      r_older     <= '0;
      r_res_valid <= 1'b0;
      r_res_tag   <= '0;
      r_res_val   <= '0;
      r_occ       <= '0;
      for (int i = 0; i < NUM_ENTRIES; i++) r_op[i] <= alu_add;
    end else if (flush) begin
      r_busy      <= '0;
      r_older     <= '0;
      r_res_valid <= 1'b0;
      r_res_tag   <= '0;
      r_res_val   <= '0;
      r_occ       <= '0;
    end else begin
      r_vj <= w_vj_n;
      r_vk <= w_vk_n;
      r_qj <= w_qj_n;
      r_qk <= w_qk_n;
      if (w_issue) begin
        r_busy[w_sel_idx] <= 1'b0;
        r_res_valid       <= 1'b1;
        r_res_tag         <= r_dest[w_sel_idx];
        r_res_val         <= w_alu_out;
      end else if (r_res_valid && res_ready) begin
        r_res_valid <= 1'b0;
      end
      if (w_disp) begin
        r_busy[w_free_idx]  <= 1'b1;
        r_op[w_free_idx]    <= alu_ops'(disp_op);
        r_vj[w_free_idx]    <= w_dvj;
        r_vk[w_free_idx]    <= w_dvk;
        r_qj[w_free_idx]    <= w_dqj;
        r_qk[w_free_idx]    <= w_dqk;
        r_dest[w_free_idx]  <= disp_dest;
        r_older[w_free_idx] <= '0;
        for (int i = 0; i < NUM_ENTRIES; i++) r_older[i][w_free_idx] <= r_busy[i];
      end
      r_occ <= r_occ + CntW'(w_disp) - CntW'(w_issue);
    end
  end

  assign res_valid = r_res_valid;
  assign res_tag   = r_res_tag;
  assign res_val   = r_res_val;
  assign occupancy = r_occ;

`ifdef ALU_RS_PERF_EN
  logic [31:0] r_perf_issue, r_perf_full;

  // Flush deliberately leaves these running; only rst clears them.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_perf_issue <= '0;
      r_perf_full  <= '0;
    end else begin
      if (w_issue && r_perf_issue != '1) r_perf_issue <= r_perf_issue + 32'd1;
      if (disp_valid && !disp_ready && r_perf_full != '1) r_perf_full <= r_perf_full + 32'd1;
    end
  end

  assign perf_issue_cnt = r_perf_issue;
  assign perf_full_cnt  = r_perf_full;
`endif

endmodule
